// File: rtl/tile_pixel_serializer.sv
// tile_pixel_serializer
//   Two-layer tile pixel serializer between the graphics ROM data bus and the
//   palette/priority stage. Each layer captures a ROM byte on its load strobe
//   into a hold register. The byte then moves to a shift stage, which presents
//   two 4-bit pixels on consecutive clocks. A mixer resolves transparency
//   (pixel 4'hF) and per-layer priority, and registers one colour index per
//   CLK_6M.
//
//   Handshake: HA2/HB2 are one-cycle load pulses with no back-pressure. GD and
//   ATTR_x are valid on the edge where the strobe is high. A byte that arrives
//   while hold is still occupied and not draining replaces the old byte and
//   raises OVF.
//
//   Ports
//     CLK_6M          pixel clock, posedge
//     RST             synchronous active-high reset
//     HA2 / HB2       layer A / B load strobes
//     GD[7:0]         ROM byte; [7:4] is the first pixel when unflipped
//     ATTR_A/ATTR_B   per-layer attribute, captured with the strobe
//     PRI_A/PRI_B     per-layer priority, used on the edge the pixel is mixed
//     FLIP            nibble-order reverse, sampled on hold->shift transfer
//     HBLANK          flushes the pipeline while high
//     PIX[11:0]       {attr, pixel} of the winning layer (12'hFFF when none)
//     OPAQUE          PIX carries an opaque pixel
//     SEL             winning layer, 0=A and 1=B
//     UNF / OVF       sticky underrun / overrun flags, cleared only by RST
//
//   Build option: define TILE_SERIALIZER_FLIP_EN to honour FLIP. If it is not
//   defined, FLIP is ignored and pixel order is always [7:4] then [3:0].
module tile_pixel_serializer (
  input  logic        CLK_6M,
  input  logic        RST,
  input  logic        HA2,
  input  logic        HB2,
  input  logic [7:0]  GD,
  input  logic [7:0]  ATTR_A,
  input  logic [7:0]  ATTR_B,
  input  logic [2:0]  PRI_A,
  input  logic [2:0]  PRI_B,
  input  logic        FLIP,
  input  logic        HBLANK,
  output logic [11:0] PIX,
  output logic        OPAQUE,
  output logic        SEL,
  output logic        UNF,
  output logic        OVF
);

  // Index 0 is layer A and index 1 is layer B throughout.
  logic [1:0][7:0] hold_data_q, hold_data_d;
  logic [1:0][7:0] hold_attr_q, hold_attr_d;
  logic [1:0]      hold_full_q, hold_full_d;
  logic [1:0][3:0] sh_first_q,  sh_first_d;
  logic [1:0][3:0] sh_second_q, sh_second_d;
  logic [1:0][7:0] sh_attr_q,   sh_attr_d;
  logic [1:0][1:0] sh_cnt_q,    sh_cnt_d;
  // A layer becomes active on its first capture after reset or HBLANK.
  // Underrun is only reported for active layers. This keeps an idle layer, or
  // the gap before the first byte of a line, from raising UNF.
  logic [1:0]      active_q,    active_d;
  logic [11:0]     pix_q,       pix_d;
  logic            opaque_q,    opaque_d;
  logic            sel_q,       sel_d;
  logic            unf_q,       unf_d;
  logic            ovf_q,       ovf_d;

  logic [1:0]      strobe;
  logic [1:0][7:0] attr_in;
  logic [1:0][3:0] cur_pix;
  logic [1:0][1:0] cnt_after;
  logic [1:0]      transfer;
  logic [1:0]      layer_op;
  logic            flip_eff;
  logic            b_wins;

`ifdef TILE_SERIALIZER_FLIP_EN
  assign flip_eff = FLIP;
`else
  logic unused_flip;
  assign unused_flip = FLIP;
  assign flip_eff    = 1'b0;
`endif

  assign strobe     = {HB2, HA2};
  assign attr_in[0] = ATTR_A;
  assign attr_in[1] = ATTR_B;

  always_comb begin
    hold_data_d = hold_data_q;
    hold_attr_d = hold_attr_q;
    hold_full_d = hold_full_q;
    sh_first_d  = sh_first_q;
    sh_second_d = sh_second_q;
    sh_attr_d   = sh_attr_q;
    sh_cnt_d    = sh_cnt_q;
    active_d    = active_q;
    unf_d       = unf_q;
    ovf_d       = ovf_q;
    cur_pix     = '1;
    cnt_after   = '0;
    transfer    = '0;
    layer_op    = '0;

    for (int i = 0; i < 2; i++) begin
      // A count of 2 presents the first pixel and a count of 1 the second.
      // An empty shift stage looks transparent to the mixer.
      if (sh_cnt_q[i] == 2'd2)      cur_pix[i] = sh_first_q[i];
      else if (sh_cnt_q[i] == 2'd1) cur_pix[i] = sh_second_q[i];
      else                          cur_pix[i] = 4'hF;
      layer_op[i]  = (sh_cnt_q[i] != 2'd0) && (cur_pix[i] != 4'hF);

      cnt_after[i] = (sh_cnt_q[i] != 2'd0) ? sh_cnt_q[i] - 2'd1 : 2'd0;
      // Refill overlaps the last pixel, so a byte every 2 cycles leaves no gap.
      transfer[i]  = hold_full_q[i] && (cnt_after[i] == 2'd0);

      if (transfer[i]) begin
        sh_first_d[i]  = flip_eff ? hold_data_q[i][3:0] : hold_data_q[i][7:4];
        sh_second_d[i] = flip_eff ? hold_data_q[i][7:4] : hold_data_q[i][3:0];
        sh_attr_d[i]   = hold_attr_q[i];
        sh_cnt_d[i]    = 2'd2;
        hold_full_d[i] = 1'b0;
      end else begin
        sh_cnt_d[i]    = cnt_after[i];
      end

      if (strobe[i]) begin
        hold_data_d[i] = GD;
        hold_attr_d[i] = attr_in[i];
        hold_full_d[i] = 1'b1;
        active_d[i]    = 1'b1;
        if (hold_full_q[i] && !transfer[i]) ovf_d = 1'b1;
      end

      if (active_q[i] && (sh_cnt_q[i] == 2'd0) && !hold_full_q[i]) unf_d = 1'b1;
    end

    // Mixer: B wins only if it is opaque and either A is transparent or B has
    // strictly higher priority. A priority tie goes to A.
    b_wins   = layer_op[1] && (!layer_op[0] || (PRI_B > PRI_A));
    pix_d    = 12'hFFF;
    opaque_d = 1'b0;
    sel_d    = 1'b0;
    if (b_wins) begin
      pix_d    = {sh_attr_q[1], cur_pix[1]};
      opaque_d = 1'b1;
      sel_d    = 1'b1;
    end else if (layer_op[0]) begin
      pix_d    = {sh_attr_q[0], cur_pix[0]};
      opaque_d = 1'b1;
    end

    // Blanking flushes the pipeline, ignores strobes and freezes the flags.
    if (HBLANK) begin
      hold_data_d = hold_data_q;
      hold_attr_d = hold_attr_q;
      hold_full_d = '0;
      sh_cnt_d    = '0;
      active_d    = '0;
      unf_d       = unf_q;
      ovf_d       = ovf_q;
      pix_d       = 12'hFFF;
      opaque_d    = 1'b0;
      sel_d       = 1'b0;
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (RST) begin
      hold_data_q <= '0;
      hold_attr_q <= '0;
      hold_full_q <= '0;
      sh_first_q  <= '0;
      sh_second_q <= '0;
      sh_attr_q   <= '0;
      sh_cnt_q    <= '0;
      active_q    <= '0;
      pix_q       <= 12'hFFF;
      opaque_q    <= 1'b0;
      sel_q       <= 1'b0;
      unf_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_attr_q <= hold_attr_d;
      hold_full_q <= hold_full_d;
      sh_first_q  <= sh_first_d;
      sh_second_q <= sh_second_d;
      sh_attr_q   <= sh_attr_d;
      sh_cnt_q    <= sh_cnt_d;
      active_q    <= active_d;
      pix_q       <= pix_d;
      opaque_q    <= opaque_d;
      sel_q       <= sel_d;
      unf_q       <= unf_d;
      ovf_q       <= ovf_d;
    end
  end

  assign PIX    = pix_q;
  assign OPAQUE = opaque_q;
  assign SEL    = sel_q;
  assign UNF    = unf_q;
  assign OVF    = ovf_q;

endmodule
